spectrogram_writer: RTL and testbench

//  Writer side of the banked spectrogram RAM that the HDMI display path reads.

---
 rtl/spectrogram_writer.sv | 207 ++++++++++++++++++++
 tb/tb_spectrogram_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrogram_writer.sv
// Spectrogram RAM writer: takes one FFT magnitude frame per ring slot,
// log-compresses each stored bin and writes it into the banked display RAM.
// After a frame is committed the oldest-slot index advances so the display
// scrolls its history by one column.
module spectrogram_writer #(
  parameter int unsigned FFT_SIZE       = 256,
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned MAG_WIDTH      = 16,
  parameter int unsigned NO_FFTS        = 50,
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  localparam int unsigned IDX_WIDTH     = $clog2(NO_FFTS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [MAG_WIDTH-1:0]      i_in_mag,
  input  logic                      i_in_first,
  input  logic                      i_in_last,
  output logic [NO_BANKS-1:0]       o_bank_wr,
  output logic [RAM_ADDR_WIDTH-1:0] o_addr_wr,
  output logic [DATA_WIDTH-1:0]     o_data_wr,
  output logic [IDX_WIDTH-1:0]      o_oldest_fft_idx,
  output logic                      o_frame_done
);

  // Only the lower half of the spectrum is stored.
  localparam int unsigned HALF_BINS      = FFT_SIZE / 2;
  localparam int unsigned SLOTS_PER_BANK = (2 ** RAM_ADDR_WIDTH) / HALF_BINS;
  // One extra bit so the bin counter can park at FFT_SIZE instead of wrapping.
  localparam int unsigned BIN_WIDTH      = $clog2(FFT_SIZE) + 1;
  localparam int unsigned DATA_MAX       = (2 ** DATA_WIDTH) - 1;

  localparam logic [BIN_WIDTH-1:0] HALF_B    = BIN_WIDTH'(HALF_BINS);
  localparam logic [BIN_WIDTH-1:0] FULL_B    = BIN_WIDTH'(FFT_SIZE);
  localparam logic [BIN_WIDTH-1:0] ONE_B     = BIN_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] LAST_SLOT = IDX_WIDTH'(NO_FFTS - 1);
  localparam logic [IDX_WIDTH-1:0] ONE_SLOT  = IDX_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic                        r_in_ready;
  logic [BIN_WIDTH-1:0]        r_bin;
  logic [IDX_WIDTH-1:0]        r_wr_slot;
  logic [IDX_WIDTH-1:0]        r_oldest;
  logic                        r_commit_q;
  logic                        r_frame_done;
  logic [NO_BANKS-1:0]         r_bank_wr;
  logic [RAM_ADDR_WIDTH-1:0]   r_addr_wr;
  logic [DATA_WIDTH-1:0]       r_data_wr;

  logic                        w_accept;
  logic                        w_wr_en;
  logic [BIN_WIDTH-1:0]        w_wr_bin;
  logic [BIN_WIDTH-1:0]        w_bin_nxt;
  logic                        w_commit;
  logic [31:0]                 w_bank_sel;
  logic [31:0]                 w_slot_base;
  logic [NO_BANKS-1:0]         w_bank_oh;
  logic [RAM_ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]       w_data;

  // floor(log2(m)) via leading-one position, clamped to the pixel range; 0 maps to 0.
  function automatic logic [DATA_WIDTH-1:0] log2_sat(input logic [MAG_WIDTH-1:0] m);
    int unsigned pos;
    pos = 0;
    for (int unsigned i = 0; i < MAG_WIDTH; i++) begin
      if (m[i]) begin
        pos = i;
      end
    end
    if (pos > DATA_MAX) begin
      pos = DATA_MAX;
    end
    return DATA_WIDTH'(pos);
  endfunction

  assign w_accept    = i_in_valid & r_in_ready;
  assign w_bank_sel  = 32'(r_wr_slot) / SLOTS_PER_BANK;
  assign w_slot_base = (32'(r_wr_slot) % SLOTS_PER_BANK) * HALF_BINS;
  assign w_bank_oh   = NO_BANKS'(1) << w_bank_sel;
  assign w_addr      = RAM_ADDR_WIDTH'(w_slot_base + 32'(w_wr_bin));
  assign w_data      = log2_sat(i_in_mag);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a frame opens on in_first and closes on in_last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && i_in_first) begin
          w_state_nxt = i_in_last ? S_COMMIT : S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept && i_in_last) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-state controls: which bin to write, how the bin counter moves, commit strobe.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_bin  = '0;
    w_bin_nxt = r_bin;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && i_in_first) begin
          w_wr_en   = 1'b1;
          w_wr_bin  = '0;
          w_bin_nxt = ONE_B;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          if (i_in_first) begin
            // Resync: restart the same slot from bin 0.
            w_wr_en   = 1'b1;
            w_wr_bin  = '0;
            w_bin_nxt = ONE_B;
          end else begin
            w_wr_en   = (r_bin < HALF_B);
            w_wr_bin  = r_bin;
            w_bin_nxt = (r_bin < FULL_B) ? (r_bin + ONE_B) : r_bin;
          end
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
      end
      default: begin
        w_commit = 1'b0;
      end
    endcase
  end

  // Handshake, bin counter and registered RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_ready <= 1'b0;
      r_bin      <= '0;
      r_bank_wr  <= '0;
      r_addr_wr  <= '0;
      r_data_wr  <= '0;
    end else begin
      r_in_ready <= (w_state_nxt != S_COMMIT);
      r_bin      <= w_bin_nxt;
      r_bank_wr  <= w_wr_en ? w_bank_oh : '0;
      if (w_wr_en) begin
        r_addr_wr <= w_addr;
        r_data_wr <= w_data;
      end
    end
  end

  // Slot ring advance, then publish the new oldest slot with a frame_done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_slot    <= '0;
      r_commit_q   <= 1'b0;
      r_oldest     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_slot <= (r_wr_slot == LAST_SLOT) ? '0 : (r_wr_slot + ONE_SLOT);
      end
      r_commit_q   <= w_commit;
      r_frame_done <= r_commit_q;
      if (r_commit_q) begin
        r_oldest <= r_wr_slot;
      end
    end
  end

  assign o_in_ready       = r_in_ready;
  assign o_bank_wr        = r_bank_wr;
  assign o_addr_wr        = r_addr_wr;
  assign o_data_wr        = r_data_wr;
  assign o_oldest_fft_idx = r_oldest;
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_spectrogram_writer.sv
// Bench for spectrogram_writer: frame-level reference model checked every
// cycle, plus fixed expectations at the interesting slots and bins.
module tb_spectrogram_writer;

  localparam int HALF  = 128;
  localparam int SPB   = 32;
  localparam int NSLOT = 50;
  localparam int NBINS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_mag = '0;
  logic        in_ready;
  logic [1:0]  bank_wr;
  logic [11:0] addr_wr;
  logic [3:0]  data_wr;
  logic [5:0]  oldest;
  logic        frame_done;

  always #5 clk = ~clk;

  spectrogram_writer dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_in_mag         (in_mag),
    .i_in_first       (in_first),
    .i_in_last        (in_last),
    .o_bank_wr        (bank_wr),
    .o_addr_wr        (addr_wr),
    .o_data_wr        (data_wr),
    .o_oldest_fft_idx (oldest),
    .o_frame_done     (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // floor(log2(m)) by repeated halving, clamped to 15; 0 -> 0.
  function automatic int lg(input logic [15:0] m);
    int k = 0;
    int unsigned v = 32'(m);
    while (v > 1) begin
      v = v >> 1;
      k++;
    end
    return (k > 15) ? 15 : k;
  endfunction

  // Reference model: frame bookkeeping in plain integers.
  bit m_init = 0;
  bit m_open, m_committing, m_pend_done, m_acc;
  int m_slot, m_bin, m_oldest;
  int e_ready, e_bank, e_addr, e_data, e_done, e_oldest;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_open = 0; m_committing = 0; m_pend_done = 0;
      m_slot = 0; m_bin = 0; m_oldest = 0;
      e_ready = 0; e_bank = 0; e_addr = 0; e_data = 0; e_done = 0; e_oldest = 0;
    end else begin
      m_acc = in_valid && (e_ready != 0);
      e_bank = 0;
      e_done = 0;
      if (m_pend_done) begin
        m_oldest = m_slot;
        e_oldest = m_oldest;
        e_done = 1;
        m_pend_done = 0;
      end
      if (m_committing) begin
        m_slot = (m_slot + 1) % NSLOT;
        m_committing = 0;
        m_pend_done = 1;
      end else if (m_acc) begin
        if (in_first) begin
          m_bin = 0;
          m_open = 1;
        end
        if (m_open) begin
          if (m_bin < HALF) begin
            e_bank = 1 << (m_slot / SPB);
            e_addr = (m_slot % SPB) * HALF + m_bin;
            e_data = lg(in_mag);
          end
          if (m_bin < NBINS) m_bin++;
          if (in_last) begin
            m_open = 0;
            m_committing = 1;
          end
        end
      end
      e_ready = m_committing ? 0 : 1;
    end
  end

  // Shadow of what the DUT wrote, for the fixed expectations.
  bit         sh_flag [2][4096];
  logic [3:0] sh_data [2][4096];
  int         wr_cnt = 0;
  int         done_cnt = 0;

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), e_ready);
      chk("bank_wr", int'(bank_wr), e_bank);
      chk("frame_done", int'(frame_done), e_done);
      chk("oldest_idx", int'(oldest), e_oldest);
      if (e_bank != 0) begin
        chk("addr_wr", int'(addr_wr), e_addr);
        chk("data_wr", int'(data_wr), e_data);
      end
    end
    if (bank_wr == 2'b01 || bank_wr == 2'b10) begin
      sh_flag[bank_wr == 2'b10 ? 1 : 0][addr_wr] = 1'b1;
      sh_data[bank_wr == 2'b10 ? 1 : 0][addr_wr] = data_wr;
      wr_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  function automatic logic [15:0] rnd();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> $urandom_range(15, 0);
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One beat: optional random gap cycles, then hold until accepted (bounded).
  task automatic beat(input logic [15:0] mag, input bit first, input bit last, input int gap);
    int g = 0;
    int waitc = 0;
    bit acc = 0;
    while (g < 3 && int'($urandom_range(99, 0)) < gap) begin
      in_valid = 1'b0;
      in_first = 1'($urandom_range(1, 0));
      in_mag   = rnd();
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b1;
    in_mag   = mag;
    in_first = first;
    in_last  = last;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      waitc++;
    end while (!acc && waitc < 20);
    if (!acc) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: mag = bin index; 1: random; 2: FFFF, 0, then random.
  task automatic frame(input int n, input int mode, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [15:0] m;
      if (mode == 0)      m = 16'(i);
      else if (mode == 2) m = (i == 0) ? 16'hFFFF : ((i == 1) ? 16'h0000 : rnd());
      else                m = rnd();
      beat(m, i == 0, i == n - 1, gap);
    end
  endtask

  int d0, w0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset for 3 cycles.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_bank_wr", int'(bank_wr), 0);
    chk("reset_addr_wr", int'(addr_wr), 0);
    chk("reset_data_wr", int'(data_wr), 0);
    chk("reset_oldest", int'(oldest), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(in_ready), 1);

    // Full 256-bin ramp into slot 0.
    w0 = wr_cnt; d0 = done_cnt;
    frame(NBINS, 0, 0);
    idle(4);
    chk("ramp_write_count", wr_cnt - w0, 128);
    chk("ramp_done_count", done_cnt - d0, 1);
    chk("ramp_bin0", int'(sh_data[0][0]), 0);
    chk("ramp_bin1", int'(sh_data[0][1]), 0);
    chk("ramp_bin2", int'(sh_data[0][2]), 1);
    chk("ramp_bin64", int'(sh_data[0][64]), 6);
    chk("ramp_bin127", int'(sh_data[0][127]), 6);
    chk("ramp_no_slot1", int'(sh_flag[0][128]), 0);
    chk("oldest_after_ramp", int'(oldest), 1);

    // Slots 1..31 with random lengths and gaps.
    for (int f = 1; f < 32; f++) frame(int'($urandom_range(200, 1)), 1, 25);
    idle(3);
    chk("oldest_after_32", int'(oldest), 32);

    // Slot 32 lands in bank 1 at address 0; saturation and zero pins.
    sh_flag[1][0] = 0; sh_flag[1][1] = 0;
    frame(10, 2, 0);
    idle(3);
    chk("slot32_bank1_addr0", int'(sh_flag[1][0]), 1);
    chk("sat_ffff", int'(sh_data[1][0]), 15);
    chk("zero_mag_written", int'(sh_flag[1][1]), 1);
    chk("zero_mag", int'(sh_data[1][1]), 0);

    // Slots 33..48, then slot 49 and the wrap.
    for (int f = 33; f < 49; f++) frame(int'($urandom_range(140, 1)), 1, 15);
    idle(3);
    chk("oldest_before_wrap", int'(oldest), 49);
    sh_flag[1][17 * 128] = 0;
    frame(HALF, 1, 10);
    idle(3);
    chk("slot49_bank1_addr", int'(sh_flag[1][17 * 128]), 1);
    chk("oldest_wrap", int'(oldest), 0);

    // Resync at bin 40 into slot 0: only the restarted frame commits.
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) beat(rnd(), i == 0, 0, 0);
    idle(2);
    chk("no_done_partial", done_cnt - d0, 0);
    frame(HALF, 1, 0);
    idle(3);
    chk("resync_done_count", done_cnt - d0, 1);
    chk("oldest_after_resync", int'(oldest), 1);

    // Gappy frame into slot 1, reset at bin 60.
    d0 = done_cnt;
    for (int i = 0; i < 60; i++) beat(rnd(), i == 0, 0, 30);
    in_valid = 1'b1;
    in_mag   = rnd();
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_midframe_bank_wr", int'(bank_wr), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset_midframe_no_done", done_cnt - d0, 0);
    chk("reset_midframe_oldest", int'(oldest), 0);
    sh_flag[0][0] = 0; sh_flag[0][128] = 0;
    frame(20, 1, 20);
    idle(3);
    chk("post_reset_slot0", int'(sh_flag[0][0]), 1);
    chk("post_reset_not_slot1", int'(sh_flag[0][128]), 0);
    chk("post_reset_oldest", int'(oldest), 1);

    // Over-long frame: beats beyond 256 bins are dropped until in_last.
    frame(300, 1, 5);
    idle(3);
    chk("oldest_after_long", int'(oldest), 2);

    // Stray beats outside frames, then random first/last fuzz.
    for (int i = 0; i < 10; i++) beat(rnd(), 0, i[0], 10);
    for (int i = 0; i < 300; i++)
      beat(rnd(), $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 5, 20);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
